// File: rtl/lfsr_gen.sv
// Parametrised LFSR generator with Fibonacci/Galois modes, seed load,
// all-zero lockup recovery and a period-wrap pulse.
module lfsr_gen #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter int               MODE  = 0
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             bit_out,
    output logic             lockup,
    output logic             wrap
);

    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be in 2..64");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_gen: SEED must be non-zero");
    end
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
        $error("lfsr_gen: MODE must be 0 or 1");
    end

    logic [WIDTH-1:0] state_q, state_d;
    logic             lockup_q, lockup_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] step_val;
    logic             fib_fb;

    always_comb begin
        fib_fb = ^(state_q & TAPS);
        if (MODE == 0) begin
            step_val = {state_q[WIDTH-2:0], fib_fb};
        end else begin
            step_val = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
        end
    end

    // Zero state never steps: it is replaced by SEED and flagged instead.
    always_comb begin
        state_d  = state_q;
        lockup_d = 1'b0;
        wrap_d   = 1'b0;
        if (load) begin
            state_d = load_val;
        end else if (en) begin
            if (state_q == '0) begin
                state_d  = SEED;
                lockup_d = 1'b1;
            end else begin
                state_d = step_val;
                wrap_d  = (step_val == SEED);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= SEED;
            lockup_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lockup_q <= lockup_d;
            wrap_q   <= wrap_d;
        end
    end

    assign out     = state_q;
    assign bit_out = (MODE == 0) ? state_q[WIDTH-1] : state_q[0];
    assign lockup  = lockup_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: 4-bit Fibonacci and Galois instances plus a
// 16-bit maximal-length instance.
module tb_lfsr_gen;

    logic       sys_clk = 1'b0;
    logic       rst4 = 1'b1, en4 = 1'b0, load4 = 1'b0;
    logic [3:0] lv4 = 4'h0;
    logic [3:0] fib_out, gal_out;
    logic       fib_bit, fib_lock, fib_wrap;
    logic       gal_bit, gal_lock, gal_wrap;

    logic        rst_w = 1'b1, en_w = 1'b0, load_w = 1'b0;
    logic [15:0] lv_w = 16'h0;
    logic [15:0] w_out;
    logic        w_bit, w_lock, w_wrap;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] fib_seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                                 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    logic [3:0] gal_seq [15] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                                 4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2};

    always #5 sys_clk = ~sys_clk;

    lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'h1), .MODE(0)) u_fib (
        .sys_clk(sys_clk), .sys_rst(rst4), .en(en4), .load(load4), .load_val(lv4),
        .out(fib_out), .bit_out(fib_bit), .lockup(fib_lock), .wrap(fib_wrap)
    );

    lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'h1), .MODE(1)) u_gal (
        .sys_clk(sys_clk), .sys_rst(rst4), .en(en4), .load(load4), .load_val(lv4),
        .out(gal_out), .bit_out(gal_bit), .lockup(gal_lock), .wrap(gal_wrap)
    );

    lfsr_gen #(.WIDTH(16), .TAPS(16'hB400), .SEED(16'h0001), .MODE(0)) u_wide (
        .sys_clk(sys_clk), .sys_rst(rst_w), .en(en_w), .load(load_w), .load_val(lv_w),
        .out(w_out), .bit_out(w_bit), .lockup(w_lock), .wrap(w_wrap)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic reset4();
        rst4 = 1'b1; en4 = 1'b0; load4 = 1'b0;
        tick();
        rst4 = 1'b0;
    endtask

    task automatic test_reset();
        rst4 = 1'b1; en4 = 1'b1; load4 = 1'b1; lv4 = 4'hA;
        tick();
        tick();
        n_checks++;
        if ({fib_out, fib_bit, fib_lock, fib_wrap} !== {4'h1, 1'b0, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_fib: out/bit/lock/wrap=%h/%b/%b/%b want 1/0/0/0",
                     fib_out, fib_bit, fib_lock, fib_wrap);
        end
        n_checks++;
        if ({gal_out, gal_bit, gal_lock, gal_wrap} !== {4'h1, 1'b1, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_gal: out/bit/lock/wrap=%h/%b/%b/%b want 1/1/0/0",
                     gal_out, gal_bit, gal_lock, gal_wrap);
        end
        rst4 = 1'b0; load4 = 1'b0; en4 = 1'b0;
    endtask

    task automatic test_fibonacci();
        logic [3:0] e;
        reset4();
        en4 = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            e = fib_seq[k % 15];
            n_checks++;
            if ({fib_out, fib_bit, fib_lock, fib_wrap} !== {e, e[3], 1'b0, (k % 15) == 0}) begin
                n_errors++;
                $display("FAIL fib_step%0d: out/bit/lock/wrap=%h/%b/%b/%b want %h/%b/0/%b",
                         k, fib_out, fib_bit, fib_lock, fib_wrap, e, e[3], (k % 15) == 0);
            end
        end
        en4 = 1'b0;
    endtask

    task automatic test_galois();
        logic [3:0] e;
        reset4();
        en4 = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            e = gal_seq[k % 15];
            n_checks++;
            if ({gal_out, gal_bit, gal_lock, gal_wrap} !== {e, e[0], 1'b0, (k % 15) == 0}) begin
                n_errors++;
                $display("FAIL gal_step%0d: out/bit/lock/wrap=%h/%b/%b/%b want %h/%b/0/%b",
                         k, gal_out, gal_bit, gal_lock, gal_wrap, e, e[0], (k % 15) == 0);
            end
        end
        en4 = 1'b0;
    endtask

    task automatic test_load_priority();
        reset4();
        load4 = 1'b1; en4 = 1'b1; lv4 = 4'h7;
        tick();
        n_checks++;
        if ({fib_out, gal_out, fib_wrap, gal_wrap} !== {4'h7, 4'h7, 2'b00}) begin
            n_errors++;
            $display("FAIL load_7: fib/gal/wraps=%h/%h/%b%b want 7/7/00",
                     fib_out, gal_out, fib_wrap, gal_wrap);
        end
        load4 = 1'b0;
        tick();
        n_checks++;
        if ({fib_out, gal_out} !== {4'hF, 4'hF}) begin
            n_errors++;
            $display("FAIL step_after_load: fib/gal=%h/%h want F/F", fib_out, gal_out);
        end
        // Loading SEED must not raise wrap.
        load4 = 1'b1; lv4 = 4'h1;
        tick();
        n_checks++;
        if ({fib_out, fib_wrap, gal_wrap} !== {4'h1, 2'b00}) begin
            n_errors++;
            $display("FAIL load_seed_nowrap: out/wraps=%h/%b%b want 1/00", fib_out, fib_wrap, gal_wrap);
        end
        // Steps from 8 (fib) and 2 (gal) land on SEED and must wrap.
        load4 = 1'b1; lv4 = 4'h8;
        tick();
        load4 = 1'b0;
        tick();
        n_checks++;
        if ({fib_out, fib_wrap, gal_out} !== {4'h1, 1'b1, 4'h4}) begin
            n_errors++;
            $display("FAIL fib_8_to_seed: out/wrap/gal=%h/%b/%h want 1/1/4", fib_out, fib_wrap, gal_out);
        end
        load4 = 1'b1; lv4 = 4'h2;
        tick();
        load4 = 1'b0;
        tick();
        n_checks++;
        if ({gal_out, gal_wrap} !== {4'h1, 1'b1}) begin
            n_errors++;
            $display("FAIL gal_2_to_seed: out/wrap=%h/%b want 1/1", gal_out, gal_wrap);
        end
        tick();
        n_checks++;
        if ({gal_wrap, fib_wrap} !== 2'b00) begin
            n_errors++;
            $display("FAIL wrap_one_cycle: gal/fib wrap=%b%b want 00", gal_wrap, fib_wrap);
        end
        en4 = 1'b0;
    endtask

    task automatic test_lockup();
        reset4();
        load4 = 1'b1; en4 = 1'b0; lv4 = 4'h0;
        tick();
        load4 = 1'b0;
        n_checks++;
        if ({fib_out, fib_lock, gal_out, gal_lock} !== {4'h0, 1'b0, 4'h0, 1'b0}) begin
            n_errors++;
            $display("FAIL load_zero: fib out/lock=%h/%b gal=%h/%b want 0/0 0/0",
                     fib_out, fib_lock, gal_out, gal_lock);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++;
            if ({fib_out, fib_lock, fib_wrap, gal_out, gal_lock} !== {4'h0, 2'b00, 4'h0, 1'b0}) begin
                n_errors++;
                $display("FAIL zero_hold%0d: fib=%h/%b/%b gal=%h/%b want 0/0/0 0/0",
                         k, fib_out, fib_lock, fib_wrap, gal_out, gal_lock);
            end
        end
        en4 = 1'b1;
        tick();
        n_checks++;
        if ({fib_out, fib_lock, fib_wrap, gal_out, gal_lock, gal_wrap} !==
            {4'h1, 2'b10, 4'h1, 2'b10}) begin
            n_errors++;
            $display("FAIL lockup_recover: fib=%h/%b/%b gal=%h/%b/%b want 1/1/0 1/1/0",
                     fib_out, fib_lock, fib_wrap, gal_out, gal_lock, gal_wrap);
        end
        en4 = 1'b0;
        tick();
        n_checks++;
        if ({fib_out, fib_lock, gal_lock} !== {4'h1, 2'b00}) begin
            n_errors++;
            $display("FAIL lockup_one_cycle: out/locks=%h/%b%b want 1/00", fib_out, fib_lock, gal_lock);
        end
    endtask

    task automatic test_enable_gating();
        int steps = 0;
        logic [3:0] e;
        reset4();
        for (int k = 0; k < 60; k++) begin
            en4 = 1'($urandom_range(0, 1));
            tick();
            if (en4) steps++;
            e = fib_seq[steps % 15];
            n_checks++;
            if ({fib_out, fib_wrap} !== {e, en4 && (steps % 15) == 0}) begin
                n_errors++;
                $display("FAIL gate%0d: out/wrap=%h/%b want %h/%b (steps=%0d)",
                         k, fib_out, fib_wrap, e, en4 && (steps % 15) == 0, steps);
            end
        end
        en4 = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        reset4();
        en4 = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        n_checks++;
        if (fib_out !== 4'hA) begin
            n_errors++;
            $display("FAIL mid_step7: out=%h want A", fib_out);
        end
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        n_checks++;
        if ({fib_out, fib_lock, fib_wrap} !== {4'h1, 2'b00}) begin
            n_errors++;
            $display("FAIL mid_reset: out/lock/wrap=%h/%b/%b want 1/0/0", fib_out, fib_lock, fib_wrap);
        end
        // Reset on the edge that would have wrapped: no pulse.
        for (int k = 0; k < 14; k++) tick();
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        n_checks++;
        if ({fib_out, fib_wrap} !== {4'h1, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_at_wrap: out/wrap=%h/%b want 1/0", fib_out, fib_wrap);
        end
        en4 = 1'b0;
    endtask

    task automatic test_wide();
        int wraps = 0;
        int zeros = 0;
        int last_wrap = -1;
        rst_w = 1'b1;
        tick();
        rst_w = 1'b0;
        n_checks++;
        if (w_out !== 16'h0001) begin
            n_errors++;
            $display("FAIL wide_reset: out=%h want 0001", w_out);
        end
        en_w = 1'b1;
        for (int k = 1; k <= 65535; k++) begin
            tick();
            if (w_wrap) begin wraps++; last_wrap = k; end
            if (w_out == 16'h0) zeros++;
        end
        en_w = 1'b0;
        n_checks++;
        if (wraps !== 1 || last_wrap !== 65535) begin
            n_errors++;
            $display("FAIL wide_wrap: wraps=%0d at step %0d want 1 at 65535", wraps, last_wrap);
        end
        n_checks++;
        if (zeros !== 0) begin
            n_errors++;
            $display("FAIL wide_nonzero: zero states seen=%0d want 0", zeros);
        end
        n_checks++;
        if (w_out !== 16'h0001) begin
            n_errors++;
            $display("FAIL wide_period_end: out=%h want 0001", w_out);
        end
        tick();
        n_checks++;
        if ({w_out, w_wrap, w_lock} !== {16'h0001, 2'b00}) begin
            n_errors++;
            $display("FAIL wide_hold: out/wrap/lock=%h/%b/%b want 0001/0/0", w_out, w_wrap, w_lock);
        end
    endtask

    initial begin
        test_reset();
        test_fibonacci();
        test_galois();
        test_load_priority();
        test_lockup();
        test_enable_gating();
        test_reset_mid_run();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
